pll_ramp_ctrl: RTL



---
 rtl/pll_ramp_pkg.sv | 43 ++++
 rtl/pll_ramp_ctrl_if.sv | 15 +
 rtl/pll_wait_timer.sv | 27 ++
 rtl/pll_ramp_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pll_ramp_pkg.sv
// Shared types and helpers for the PLL ramp sequencer.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
package pll_ramp_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOCK,
    ST_HOP,
    ST_RUN,
    ST_GATE,
    ST_PDN
  } state_t;

  // Counter width able to hold the longest of the three waits.
  function automatic int unsigned cnt_w(input int unsigned lock_cyc,
                                        input int unsigned pdn_cyc,
                                        input int unsigned gate_cyc);
    int unsigned mx;
    mx = lock_cyc;
    if (pdn_cyc > mx) mx = pdn_cyc;
    if (gate_cyc > mx) mx = gate_cyc;
    return int'($clog2(mx + 1));
  endfunction

  // One hop of the multiplier toward the target, never overshooting.
  // Operands arrive zero-extended to 32 bits, so for any code width below
  // 32 the difference is at least one bit wider than the code and
  // cur +/- step can neither wrap nor pass the target.
  function automatic int unsigned next_m(input int unsigned cur,
                                         input int unsigned tgt,
                                         input int unsigned step);
    int unsigned d;
    if (tgt >= cur) begin
      d = tgt - cur;
      return cur + ((d < step) ? d : step);
    end else begin
      d = cur - tgt;
      return cur - ((d < step) ? d : step);
    end
  endfunction

endpackage

// File: rtl/pll_ramp_ctrl_if.sv
// Request channel into the PLL ramp sequencer (target M/N, valid/ready).
// Latency: n/a (wiring only).
// Backpressure: cfg_ready is low while a ramp or power cycle is in flight.
interface pll_ramp_ctrl_if #(
  parameter int unsigned M_W = 8,
  parameter int unsigned N_W = 8
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [M_W-1:0] cfg_m;
  logic [N_W-1:0] cfg_n;

  modport master (output cfg_valid, output cfg_m, output cfg_n, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_m, input cfg_n, output cfg_ready);
endinterface

// File: rtl/pll_wait_timer.sv
// Loadable down-counter with a zero flag, shared by every timed state.
// Latency: a load of K-1 makes o_zero rise K-1 cycles later.
// Backpressure: none; it saturates at zero until reloaded.
module pll_wait_timer #(
  parameter int unsigned CW = 11
) (
  input  logic          osc_clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;

  // Reload on state entry, otherwise count down and hold at zero.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pll_ramp_ctrl.sv
// PLL sequencer: power-up, bounded-step M ramp with lock-waits, gated N change/shutdown.
// Latency: GATE_CYC + hops*(1+LOCK_CYC) (+PDN_CYC+LOCK_CYC on N change) from accept to RUN.
// Backpressure: cfg_ready only in OFF/RUN; requests elsewhere are dropped, never queued.
module pll_ramp_ctrl
  import pll_ramp_pkg::*;
#(
  parameter int unsigned M_W      = 8,
  parameter int unsigned N_W      = 8,
  parameter int unsigned M_MIN    = 8,
  parameter int unsigned DEF_N    = 1,
  parameter int unsigned M_STEP   = 4,
  parameter int unsigned LOCK_CYC = 2000,
  parameter int unsigned PDN_CYC  = 16,
  parameter int unsigned GATE_CYC = 4
) (
  input  logic            osc_clk,
  input  logic            rst_n,
  pll_ramp_ctrl_if.slave  cfg,
  output logic [M_W-1:0]  pll_m,
  output logic [N_W-1:0]  pll_n,
  output logic            pll_pdn,
  output logic            clk_en,
  output logic            busy,
  output logic            done
);
  localparam int unsigned CW = cnt_w(LOCK_CYC, PDN_CYC, GATE_CYC);

  state_t         r_state, w_next;
  logic [M_W-1:0] r_pll_m, w_pll_m, r_tgt_m, w_cfg_tgt_m, w_hop_m;
  logic [N_W-1:0] r_pll_n, w_pll_n, r_tgt_n;
  logic           r_pdn, r_clk_en, r_done;
  logic           w_ready, w_accept, w_tmr_zero, w_tmr_load, w_done_set;
  logic [CW-1:0]  w_tmr_val;

  assign w_ready       = (r_state == ST_OFF) || (r_state == ST_RUN);
  assign cfg.cfg_ready = w_ready;
  assign busy          = !w_ready;
  assign w_accept      = cfg.cfg_valid && w_ready;

  // Zero means shut down; any other target is clamped up to the power-up code.
  assign w_cfg_tgt_m = (cfg.cfg_m == '0)           ? '0 :
                       (cfg.cfg_m < M_W'(M_MIN))   ? M_W'(M_MIN) : cfg.cfg_m;
  assign w_hop_m     = M_W'(next_m(32'(r_pll_m), 32'(r_tgt_m), M_STEP));

  pll_wait_timer #(.CW(CW)) u_timer (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_val   (w_tmr_val),
    .o_zero  (w_tmr_zero)
  );

  // Next state, next pin codes, timer load on timed-state entry and done request.
  always_comb begin
    w_next     = r_state;
    w_pll_m    = r_pll_m;
    w_pll_n    = r_pll_n;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_done_set = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_accept) begin
          if (w_cfg_tgt_m == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_next  = ST_LOCK;
            w_pll_m = M_W'(M_MIN);
            w_pll_n = cfg.cfg_n;
          end
        end
      end
      ST_LOCK: begin
        if (w_tmr_zero) w_next = (r_pll_m == r_tgt_m) ? ST_RUN : ST_HOP;
      end
      ST_HOP: begin
        w_pll_m = w_hop_m;
        w_next  = ST_LOCK;
      end
      ST_RUN: begin
        if (w_accept) w_next = ST_GATE;
      end
      ST_GATE: begin
        if (w_tmr_zero) begin
          if ((r_tgt_m == '0) || (r_tgt_n != r_pll_n)) w_next = ST_PDN;
          else if (r_tgt_m == r_pll_m)                 w_next = ST_RUN;
          else                                         w_next = ST_HOP;
        end
      end
      ST_PDN: begin
        if (w_tmr_zero) begin
          if (r_tgt_m == '0) begin
            w_next = ST_OFF;
          end else begin
            w_next  = ST_LOCK;
            w_pll_m = M_W'(M_MIN);
            w_pll_n = r_tgt_n;
          end
        end
      end
      default: w_next = ST_OFF;
    endcase
    // Each timed state starts at K-1 so it occupies exactly K cycles.
    if (w_next != r_state) begin
      case (w_next)
        ST_LOCK: begin w_tmr_load = 1'b1; w_tmr_val = CW'(LOCK_CYC - 1); end
        ST_GATE: begin w_tmr_load = 1'b1; w_tmr_val = CW'(GATE_CYC - 1); end
        ST_PDN:  begin w_tmr_load = 1'b1; w_tmr_val = CW'(PDN_CYC - 1);  end
        default: ;
      endcase
      if ((w_next == ST_RUN) || (w_next == ST_OFF)) w_done_set = 1'b1;
    end
  end

  // State, pin codes and glitch-free registered PLL/gate outputs.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_pll_m  <= M_W'(M_MIN);
      r_pll_n  <= N_W'(DEF_N);
      r_tgt_m  <= '0;
      r_tgt_n  <= N_W'(DEF_N);
      r_pdn    <= 1'b0;
      r_clk_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pll_m  <= w_pll_m;
      r_pll_n  <= w_pll_n;
      r_pdn    <= (w_next == ST_LOCK) || (w_next == ST_HOP) ||
                  (w_next == ST_RUN)  || (w_next == ST_GATE);
      r_clk_en <= (w_next == ST_RUN);
      r_done   <= w_done_set;
      if (w_accept) begin
        r_tgt_m <= w_cfg_tgt_m;
        r_tgt_n <= cfg.cfg_n;
      end
    end
  end

  assign pll_m   = r_pll_m;
  assign pll_n   = r_pll_n;
  assign pll_pdn = r_pdn;
  assign clk_en  = r_clk_en;
  assign done    = r_done;
endmodule
